// File: rtl/hp_vpu_pkg.sv
// Shared VPU pipeline types: instruction pipe classes, stall causes and default latencies.
package hp_vpu_pkg;

    localparam int DEF_NVREG   = 32;
    localparam int DEF_LAT_ALU = 2;
    localparam int DEF_LAT_MUL = 3;
    localparam int DEF_LAT_MAC = 4;

    typedef enum logic [1:0] {
        PIPE_ALU = 2'd0,
        PIPE_MUL = 2'd1,
        PIPE_MAC = 2'd2
    } pipe_class_e;

    typedef enum logic [1:0] {
        STALL_NONE = 2'd0,
        STALL_RAW  = 2'd1,
        STALL_WAW  = 2'd2,
        STALL_WBP  = 2'd3
    } stall_cause_e;

endpackage

// File: rtl/hp_vpu_sb_cnt.sv
// Per-register countdown: cycles remaining until the pending VRF write lands (0 = clean).
module hp_vpu_sb_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] value_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            value_reg <= '0;
        end else if (load) begin
            value_reg <= load_val;
        end else if (value_reg != '0) begin
            value_reg <= value_reg - 1'b1;
        end
    end

    assign value = value_reg;
    assign zero  = (value_reg == '0);

endmodule

// File: rtl/hp_vpu_hazard_scoreboard.sv
// Issue-stage scoreboard: RAW/WAW tracking per vector register, VRF write-port
// reservation, DMA gating and stall accounting.
module hp_vpu_hazard_scoreboard
    import hp_vpu_pkg::*;
#(
    parameter int NVREG   = DEF_NVREG,
    parameter int LAT_ALU = DEF_LAT_ALU,
    parameter int LAT_MUL = DEF_LAT_MUL,
    parameter int LAT_MAC = DEF_LAT_MAC,
    parameter int CNT_W   = $clog2(LAT_MAC + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iss_valid_i,
    output logic        iss_ready_o,
    input  logic [1:0]  iss_class_i,
    input  logic [4:0]  iss_vd_i,
    input  logic [4:0]  iss_vs1_i,
    input  logic [4:0]  iss_vs2_i,
    input  logic        iss_use_vs1_i,
    input  logic        iss_use_vs2_i,
    input  logic        iss_vd_rd_i,
    input  logic        iss_vd_we_i,
    input  logic        flush_i,
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [4:0]  dma_addr_i,
    output logic        dma_gnt_o,
    output logic        wb_now_o,
    output logic [1:0]  stall_cause_o,
    output logic        busy_o,
    output logic [31:0] stall_cnt_o
);

    logic [CNT_W-1:0] cnt_val [NVREG];
    logic [NVREG-1:0] cnt_zero;
    logic [NVREG-1:0] cnt_load;
    logic [NVREG-1:0] cnt_busy;

    logic [LAT_MAC:0] res_reg;
    logic [LAT_MAC:0] res_next;
    logic [31:0]      stall_cnt_reg;

    logic [CNT_W-1:0] lat_sel;
    logic [CNT_W-1:0] lat_m1;
    logic             raw, waw, wbp;
    logic             accept_we;
    stall_cause_e     cause;

    // Illegal class 3 falls through to the MAC latency.
    always_comb begin
        lat_sel = CNT_W'(LAT_MAC);
        case (iss_class_i)
            PIPE_ALU: lat_sel = CNT_W'(LAT_ALU);
            PIPE_MUL: lat_sel = CNT_W'(LAT_MUL);
            default:  ;
        endcase
    end
    assign lat_m1 = lat_sel - 1'b1;

    assign raw = (iss_use_vs1_i & ~cnt_zero[iss_vs1_i])
               | (iss_use_vs2_i & ~cnt_zero[iss_vs2_i])
               | (iss_vd_rd_i   & ~cnt_zero[iss_vd_i]);
    assign waw = iss_vd_we_i & ~cnt_zero[iss_vd_i];
    // A write issued now lands lat_sel cycles out; that slot must be free.
    assign wbp = iss_vd_we_i & res_reg[lat_sel];

    assign iss_ready_o = ~(raw | waw | wbp) & ~flush_i;
    assign accept_we   = iss_valid_i & iss_ready_o & iss_vd_we_i;

    always_comb begin
        cause = STALL_NONE;
        if (iss_valid_i) begin
            if (raw)      cause = STALL_RAW;
            else if (waw) cause = STALL_WAW;
            else if (wbp) cause = STALL_WBP;
        end
    end
    assign stall_cause_o = cause;

    genvar gi;
    generate
        for (gi = 0; gi < NVREG; gi++) begin : g_cnt
            assign cnt_load[gi] = accept_we & (iss_vd_i == 5'(gi));
            assign cnt_busy[gi] = |cnt_val[gi];

            hp_vpu_sb_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (flush_i),
                .load     (cnt_load[gi]),
                .load_val (lat_sel),
                .value    (cnt_val[gi]),
                .zero     (cnt_zero[gi])
            );
        end
    endgenerate

    always_comb begin
        res_next = res_reg >> 1;
        if (accept_we) res_next[lat_m1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            res_reg <= '0;
        end else begin
            res_reg <= res_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (iss_valid_i && !iss_ready_o && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign wb_now_o    = res_reg[0];
    assign busy_o      = |cnt_busy;
    assign stall_cnt_o = stall_cnt_reg;
    // DMA writes yield to a pipeline write landing this cycle.
    assign dma_gnt_o   = dma_req_i & cnt_zero[dma_addr_i] & ~(dma_we_i & res_reg[0]);

endmodule

// File: tb/tb_hp_vpu_hazard_scoreboard.sv
// Directed scoreboard bench: the driver queues expected observations and accept
// cycles; a negedge monitor pops and compares them against the DUT.
module tb_hp_vpu_hazard_scoreboard;

    localparam int C_ALU = 0, C_MUL = 1, C_MAC = 2;
    localparam int S_READY = 0, S_CAUSE = 1, S_WB = 2, S_BUSY = 3, S_GNT = 4, S_STALL = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid_i, iss_ready_o;
    logic [1:0]  iss_class_i;
    logic [4:0]  iss_vd_i, iss_vs1_i, iss_vs2_i;
    logic        iss_use_vs1_i, iss_use_vs2_i, iss_vd_rd_i, iss_vd_we_i;
    logic        flush_i, dma_req_i, dma_we_i;
    logic [4:0]  dma_addr_i;
    logic        dma_gnt_o, wb_now_o, busy_o;
    logic [1:0]  stall_cause_o;
    logic [31:0] stall_cnt_o;

    hp_vpu_hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid_i(iss_valid_i), .iss_ready_o(iss_ready_o), .iss_class_i(iss_class_i),
        .iss_vd_i(iss_vd_i), .iss_vs1_i(iss_vs1_i), .iss_vs2_i(iss_vs2_i),
        .iss_use_vs1_i(iss_use_vs1_i), .iss_use_vs2_i(iss_use_vs2_i),
        .iss_vd_rd_i(iss_vd_rd_i), .iss_vd_we_i(iss_vd_we_i), .flush_i(flush_i),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
        .dma_gnt_o(dma_gnt_o), .wb_now_o(wb_now_o), .stall_cause_o(stall_cause_o),
        .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    int   exp_stalls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sig_name(int s);
        case (s)
            S_READY: return "iss_ready";
            S_CAUSE: return "stall_cause";
            S_WB:    return "wb_now";
            S_BUSY:  return "busy";
            S_GNT:   return "dma_gnt";
            default: return "stall_cnt";
        endcase
    endfunction

    function automatic logic [31:0] sig_val(int s);
        case (s)
            S_READY: return 32'(iss_ready_o);
            S_CAUSE: return 32'(stall_cause_o);
            S_WB:    return 32'(wb_now_o);
            S_BUSY:  return 32'(busy_o);
            S_GNT:   return 32'(dma_gnt_o);
            default: return stall_cnt_o;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   ac;
        if (iss_valid_i === 1'b1 && iss_ready_o === 1'b1) begin
            vectors++;
            if (acc_q.size() == 0) begin
                errors++;
                $display("FAIL accept cyc=%0d actual=accepted required=no accept", cyc);
            end else begin
                ac = acc_q.pop_front();
                if (ac != cyc) begin
                    errors++;
                    $display("FAIL accept actual_cyc=%0d required_cyc=%0d", cyc, ac);
                end else begin
                    $display("accept cyc=%0d ok", cyc);
                end
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (e.cyc != cyc || sig_val(e.sig) !== e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d actual=%0h required=%0h (due cyc %0d)",
                         sig_name(e.sig), cyc, sig_val(e.sig), e.val, e.cyc);
            end else begin
                $display("check %s cyc=%0d value=%0h ok", sig_name(e.sig), cyc, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(int s, logic [31:0] v);
        exp_t e;
        e.cyc = cyc;
        e.sig = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic acc();
        acc_q.push_back(cyc);
    endtask

    task automatic iss(int cls, int vd, int vs1, int vs2, bit u1, bit u2, bit rd, bit we);
        iss_valid_i   = 1'b1;
        iss_class_i   = 2'(cls);
        iss_vd_i      = 5'(vd);
        iss_vs1_i     = 5'(vs1);
        iss_vs2_i     = 5'(vs2);
        iss_use_vs1_i = u1;
        iss_use_vs2_i = u2;
        iss_vd_rd_i   = rd;
        iss_vd_we_i   = we;
    endtask

    task automatic idle();
        iss(C_ALU, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        iss_valid_i = 1'b0;
    endtask

    task automatic idle_n(int n);
        repeat (n) begin
            tick();
            idle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush_i = 1'b0;
        dma_req_i = 1'b0; dma_we_i = 1'b0; dma_addr_i = '0;
        idle();
        repeat (3) tick();

        // Reset state
        rst_n = 1'b1; dma_req_i = 1'b1;
        chk(S_READY, 1); chk(S_WB, 0); chk(S_BUSY, 0); chk(S_STALL, 0); chk(S_GNT, 1);
        tick(); dma_req_i = 1'b0;

        // MAC producer then dependent vadd: RAW for 4 cycles, write seen at t0+4
        tick(); iss(C_MAC, 4, 1, 2, 0, 0, 1, 1); acc(); chk(S_BUSY, 0);
        for (int k = 1; k <= 4; k++) begin
            tick(); iss(C_ALU, 5, 4, 1, 1, 1, 0, 1);
            chk(S_READY, 0); chk(S_CAUSE, 1); chk(S_WB, (k == 4) ? 1 : 0);
            if (k == 1) chk(S_BUSY, 1);
            exp_stalls++;
        end
        tick(); acc(); chk(S_READY, 1); chk(S_CAUSE, 0); chk(S_WB, 0);
        idle_n(6);

        // ALU producer, accumulator read of same reg: accepted at t0+3
        tick(); iss(C_ALU, 6, 1, 2, 1, 1, 0, 1); acc();
        for (int k = 1; k <= 2; k++) begin
            tick(); iss(C_MAC, 6, 3, 0, 1, 0, 1, 1);
            chk(S_READY, 0); chk(S_CAUSE, 1);
            exp_stalls++;
        end
        tick(); acc();
        idle_n(6);

        // Back-to-back vmacc v7: reload, busy through t0+9
        tick(); iss(C_MAC, 7, 1, 0, 1, 0, 1, 1); acc();
        for (int k = 1; k <= 4; k++) begin
            tick(); chk(S_READY, 0); chk(S_CAUSE, 1);
            exp_stalls++;
        end
        tick(); acc();
        for (int k = 6; k <= 10; k++) begin
            tick(); idle(); chk(S_BUSY, (k <= 9) ? 1 : 0);
        end
        idle_n(2);

        // Pure WAW: vmul v8 then vadd v8 without reading v8
        tick(); iss(C_MUL, 8, 1, 2, 1, 1, 0, 1); acc();
        for (int k = 1; k <= 3; k++) begin
            tick(); iss(C_ALU, 8, 1, 2, 1, 1, 0, 1);
            chk(S_READY, 0); chk(S_CAUSE, 2);
            exp_stalls++;
        end
        tick(); acc(); chk(S_CAUSE, 0);
        idle_n(5);

        // Write-port collision: MAC at t0, independent ALU at t0+2
        tick(); iss(C_MAC, 4, 2, 0, 1, 0, 1, 1); acc(); chk(S_WB, 0);
        tick(); idle(); chk(S_READY, 1); chk(S_CAUSE, 0); chk(S_WB, 0);
        tick(); iss(C_ALU, 20, 1, 1, 1, 1, 0, 1); chk(S_READY, 0); chk(S_CAUSE, 3); chk(S_WB, 0);
        exp_stalls++;
        tick(); acc(); chk(S_WB, 0);
        tick(); idle(); chk(S_WB, 1);
        tick(); chk(S_WB, 1);
        tick(); chk(S_WB, 0);
        idle_n(4);

        // DMA read gated by in-flight vmul v9
        tick(); iss(C_MUL, 9, 1, 2, 1, 1, 0, 1); acc();
        for (int k = 1; k <= 4; k++) begin
            tick(); idle(); dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 5'd9;
            chk(S_GNT, (k == 4) ? 1 : 0);
        end
        tick(); dma_req_i = 1'b0;
        idle_n(2);
        // DMA write of clean v3 yields to the vmul writeback at t1+3
        tick(); iss(C_MUL, 9, 1, 2, 1, 1, 0, 1); acc();
        tick(); idle();
        for (int k = 2; k <= 4; k++) begin
            tick(); dma_req_i = 1'b1; dma_we_i = 1'b1; dma_addr_i = 5'd3;
            chk(S_GNT, (k == 3) ? 0 : 1); chk(S_WB, (k == 3) ? 1 : 0);
        end
        tick(); dma_req_i = 1'b0; dma_we_i = 1'b0;
        idle_n(3);
        tick(); chk(S_STALL, 32'(exp_stalls));

        // Flush with cnt[v4]=3
        tick(); iss(C_MAC, 4, 2, 0, 1, 0, 1, 1); acc();
        tick(); idle(); chk(S_BUSY, 1);
        tick(); iss(C_ALU, 5, 4, 1, 1, 1, 0, 1); flush_i = 1'b1;
        chk(S_READY, 0); chk(S_CAUSE, 1);
        exp_stalls++;
        tick(); flush_i = 1'b0; acc(); chk(S_READY, 1); chk(S_BUSY, 0); chk(S_WB, 0);
        tick(); iss(C_ALU, 10, 1, 2, 1, 1, 0, 1); flush_i = 1'b1;
        chk(S_READY, 0); chk(S_CAUSE, 0); chk(S_BUSY, 1);
        exp_stalls++;
        tick(); flush_i = 1'b0; idle();
        chk(S_BUSY, 0); chk(S_WB, 0); chk(S_STALL, 32'(exp_stalls));
        idle_n(2);

        // Mid-flight reset with cnt[v4]=3
        tick(); iss(C_MAC, 4, 2, 0, 1, 0, 1, 1); acc();
        tick(); idle();
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1; iss(C_ALU, 5, 4, 1, 1, 1, 0, 1); acc();
        chk(S_READY, 1); chk(S_BUSY, 0); chk(S_STALL, 0); chk(S_WB, 0);
        dma_req_i = 1'b1; dma_we_i = 1'b1; dma_addr_i = 5'd4; chk(S_GNT, 1);
        tick(); idle(); dma_req_i = 1'b0; dma_we_i = 1'b0; chk(S_BUSY, 1);
        idle_n(4);

        @(negedge clk);
        #1;
        if (acc_q.size() != 0) begin
            errors++;
            $display("FAIL pending_accepts actual=%0d required=0", acc_q.size());
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_checks actual=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/hp_vpu_hazard_scoreboard.md
Name: hp_vpu_hazard_scoreboard

Overview:
Issue-stage scoreboard and scheduler for the VPU pipeline. It tracks pending vector-register writes from ALU, MUL (E1m) and MAC instruction classes, each with its own latency. Issue is stalled on three conditions: a RAW hazard, a WAW hazard, or a collision on the single VRF write port. It also gates DMA access to registers that still have a write in flight. It sits between the CV-X-IF issue decoder and the execute pipeline.

Parameters:
NVREG, 32, number of vector registers tracked
LAT_ALU, 2, cycles from issue accept to VRF write for non-MAC ops (vadd/vand…)
LAT_MUL, 3, same for vmul
LAT_MAC, 4, same for vmacc/vmadd; must satisfy LAT_ALU <= LAT_MUL <= LAT_MAC
CNT_W, $clog2(LAT_MAC+1), per-register countdown width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
iss_valid_i  in  1  decoded instruction presented
iss_ready_o  out  1  instruction accepted when valid&ready
iss_class_i  in  2  pipe_class_e: ALU=0, MUL=1, MAC=2 (3 is illegal; treated as MAC)
iss_vd_i  in  5  destination register
iss_vs1_i  in  5  source 1
iss_vs2_i  in  5  source 2
iss_use_vs1_i  in  1  vs1 is read
iss_use_vs2_i  in  1  vs2 is read
iss_vd_rd_i  in  1  vd is also read (accumulator, MAC)
iss_vd_we_i  in  1  instruction writes vd
flush_i  in  1  kill all in-flight tracking
dma_req_i  in  1  DMA VRF access request
dma_we_i  in  1  DMA write
dma_addr_i  in  5  DMA register
dma_gnt_o  out  1  DMA access allowed this cycle
wb_now_o  out  1  pipeline writes VRF this cycle
stall_cause_o  out  2  0 none, 1 RAW, 2 WAW, 3 WB-port
busy_o  out  1  any write in flight
stall_cnt_o  out  32  saturating count of cycles with iss_valid_i&!iss_ready_o

Behaviour:
- LAT(c) = LAT_ALU, LAT_MUL, or LAT_MAC according to iss_class_i.
- cnt[r]: remaining cycles until vr is written. 0 = clean.
  - On accept with iss_vd_we_i: cnt[vd] <= LAT(c).
  - Otherwise every nonzero cnt decrements by 1 each cycle. A load on accept overrides the decrement for that register.
- res[LAT_MAC:0] write-port reservation vector: bit k set means a VRF write occurs k cycles from now.
  - Next state: res_n = res>>1, OR (1<<(LAT(c)-1)) on an accepted write.
  - wb_now_o = res[0]. cnt[r]==1 coincides with the res[0] for that write.
- Stall conditions, evaluated combinationally from current state:
  - RAW = (use_vs1 & cnt[vs1]!=0) | (use_vs2 & cnt[vs2]!=0) | (vd_rd & cnt[vd]!=0)
  - WAW = vd_we & cnt[vd]!=0
  - WBP = vd_we & res[LAT(c)]
- iss_ready_o = !(RAW|WAW|WBP) & !flush_i.
  - Ready is computed without regard to iss_valid_i; the accept is valid&ready.
  - The same-cycle ready is not registered.
- stall_cause_o is meaningful only when iss_valid_i is high; otherwise it is 0. Priority RAW > WAW > WBP.
- No forwarding: a dependent instruction issued at t0+1 after a producer accepted at t0 is accepted at exactly t0+LAT+1.
- dma_gnt_o = dma_req_i & cnt[dma_addr_i]==0 & !(dma_we_i & res[0]). DMA never preempts a pipeline write.
- busy_o = |cnt.
- flush_i: next cycle all cnt=0, res=0, and iss_ready_o=0 during the flush cycle. flush_i has priority over a simultaneous valid.
- Reset (including mid-operation): all cnt=0, res=0, stall_cnt_o=0. Resulting output values: iss_ready_o=1 (when no hazards), dma_gnt_o=dma_req_i, wb_now_o=0, busy_o=0.
- stall_cnt_o saturates at 32'hFFFF_FFFF and does not wrap.
- An instruction with vd_we=0 does not modify cnt or res.

Decomposition:
- Add to hp_vpu_pkg:
  - pipe_class_e enum
  - LAT_ALU/LAT_MUL/LAT_MAC defaults
  - stall_cause_e enum
- The per-register countdown is natural as a sub-module, hp_vpu_sb_cnt, with load, value, and zero flag, instantiated NVREG times via generate.
- The reservation shift register and stall logic live inline.

Test Plan:
1. MAC vd=v4 accepted t0; vadd v5,v4,v1 valid from t0+1. Required: ready=0 and cause=RAW for t0+1..t0+4; accepted at t0+5; wb_now_o=1 at t0+4.
2. vadd vd=v6 at t0; vmacc v6 (vd_rd=1) at t0+1. Required: stall with cause RAW; accepted at t0+3 (LAT_ALU+1).
3. vmacc v7 at t0; vmacc v7 at t0+1. Required: accepted at t0+5; cnt[v7] reloads to 4; busy_o stays high until t0+9.
4. vmacc v4 at t0; independent vand v20,v1,v1 at t0+2. Required: WBP stall at t0+2 (res[2] set); accepted t0+3; wb_now_o high at t0+4 and t0+5, never with two writes in one cycle.
5. vmul vd=v9 at t0; DMA read of v9 at t0+1. Required: dma_gnt_o=0 through t0+3, 1 at t0+4. DMA write of v3 at t0+3 is denied (res[0]=1), granted at t0+4.
6. Mid-flight flush_i or rst_n=0 with cnt[v4]=3. Required: next cycle busy_o=0, iss_ready_o=1, dependent instruction accepted immediately; stall_cnt_o=0 after reset.
